// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, skid-buffer state encoding and gray decode.
package fifo_pkg;

    localparam int FIFO_DATA_SIZE = 8;
    localparam int FIFO_ADDR_SIZE = 5;
    localparam int GRAY_MAX_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Prefix-XOR from the MSB down; bits at or above w decode to zero.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                       input int w);
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        b   = '0;
        acc = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < w) acc = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer (EMPTY/ONE/TWO) with valid/ready on both sides and a registered up_ready.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = FIFO_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up_valid,
    input  logic [DATA_SIZE-1:0] up_data,
    output logic                 up_ready,
    output logic                 dn_valid,
    output logic [DATA_SIZE-1:0] dn_data,
    input  logic                 dn_ready
);

    skid_state_t          state, state_next;
    logic [DATA_SIZE-1:0] head, tail, head_next, tail_next;
    logic                 push, pop;

    assign push     = up_valid & up_ready;
    assign dn_valid = (state != EMPTY);
    assign pop      = dn_valid & dn_ready;
    assign dn_data  = head;

    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_next  = up_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = TWO;
                    tail_next  = up_data;
                end else if (!push && pop) begin
                    state_next = EMPTY;
                end else if (push && pop) begin
                    head_next = up_data;
                end
            end
            TWO: begin
                // up_ready is low here, so only a pop can move the state
                if (pop) begin
                    state_next = ONE;
                    head_next  = tail;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            up_ready <= 1'b0;
        end else begin
            state    <= state_next;
            head     <= head_next;
            tail     <= tail_next;
            up_ready <= (state_next != TWO);
        end
    end

endmodule

// File: rtl/fifo_wr_stream.sv
// Write-side stream client of the async FIFO: skid buffer into winc/wdata plus wclk-domain level.
// Optional counters wr_count/stall_count are built when FIFO_WR_STREAM_STATS_EN is defined.
module fifo_wr_stream
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE    = FIFO_DATA_SIZE,
    parameter int ADDR_SIZE    = FIFO_ADDR_SIZE,
    parameter int AFULL_THRESH = 28
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 s_ready,
    output logic                 winc,
    output logic [DATA_SIZE-1:0] wdata,
    input  logic                 wfull,
    input  logic [ADDR_SIZE:0]   wptr,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 walmost_full
`ifdef FIFO_WR_STREAM_STATS_EN
    ,
    output logic [31:0]          wr_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int PW = ADDR_SIZE + 1;

    logic          buf_valid;
    logic [PW-1:0] wbin, rbin, level_next;

    fifo_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk      (wclk),
        .rst_n    (wrst_n),
        .up_valid (s_valid),
        .up_data  (s_data),
        .up_ready (s_ready),
        .dn_valid (buf_valid),
        .dn_data  (wdata),
        .dn_ready (~wfull)
    );

    assign winc = buf_valid & ~wfull;

    // Stale read pointer makes the difference an overestimate; modular subtraction covers wrap.
    assign wbin       = PW'(gray2bin(GRAY_MAX_W'(wptr), PW));
    assign rbin       = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr), PW));
    assign level_next = wbin - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= PW'(AFULL_THRESH));
        end
    end

`ifdef FIFO_WR_STREAM_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (winc)              wr_count    <= sat_inc(wr_count);
            if (buf_valid && wfull) stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_stream.sv
// Scoreboard bench for fifo_wr_stream: accepted words queued, monitor checks winc/wdata order.
module tb_fifo_wr_stream;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int PW = AW + 1;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull = 1'b0;
    logic [PW-1:0] wptr = '0;
    logic [PW-1:0] wq2_rptr = '0;
    logic [PW-1:0] wlevel;
    logic          walmost_full;
`ifdef FIFO_WR_STREAM_STATS_EN
    logic [31:0]   wr_count;
    logic [31:0]   stall_count;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];

    fifo_wr_stream #(
        .DATA_SIZE    (DW),
        .ADDR_SIZE    (AW),
        .AFULL_THRESH (28)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .wptr         (wptr),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
`ifdef FIFO_WR_STREAM_STATS_EN
        ,
        .wr_count     (wr_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Scoreboard: every word accepted by the DUT is expected later on wdata, in order.
    always @(posedge wclk) begin
        if (wrst_n && s_valid && s_ready) exp_q.push_back(s_data);
    end

    // Monitor: every winc must carry the oldest outstanding word and never coincide with wfull.
    always @(negedge wclk) begin
        if (wrst_n && winc) begin
            check("winc_gated_by_wfull", 32'(wfull), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: wdata 0x%0h, scoreboard empty", wdata);
            end else begin
                check("wdata_order", 32'(wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic stream(input int n, input logic [DW-1:0] start);
        int  sent = 0;
        int  guard = 0;
        logic acc;
        s_valid = 1'b1;
        s_data  = start;
        while (sent < n && guard < 200) begin
            @(negedge wclk);
            acc = s_ready;
            @(posedge wclk);
            #1;
            guard++;
            if (acc) begin
                sent++;
                s_data = DW'(int'(start) + sent);
            end
        end
        s_valid = 1'b0;
        if (sent < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: sent %0d, required %0d", sent, n);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge wclk);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_winc"}, 32'(winc), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        check({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
    endtask

    task automatic level_case(input string tag, input logic [PW-1:0] wb, input logic [PW-1:0] rb,
                              input logic [PW-1:0] exp_lvl, input logic exp_af);
        wptr     = gray(wb);
        wq2_rptr = gray(rb);
        @(posedge wclk);
        #1;
        check({tag, "_wlevel"}, 32'(wlevel), 32'(exp_lvl));
        check({tag, "_walmost_full"}, 32'(walmost_full), 32'(exp_af));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #2;
        check_outputs_zero("reset");
        @(negedge wclk);
        wrst_n = 1'b1;

        // Sustained stream: ready after first edge, winc every cycle from the second
        fork
            stream(10, 8'h01);
            begin
                @(negedge wclk);
                check("first_ready", 32'(s_ready), 32'd1);
                check("first_winc", 32'(winc), 32'd0);
                @(negedge wclk);
                check("latency_winc", 32'(winc), 32'd1);
                check("latency_wdata", 32'(wdata), 32'h01);
                @(negedge wclk);
                check("push_pop_one_wdata", 32'(wdata), 32'h02);
                for (int i = 0; i < 7; i++) begin
                    @(negedge wclk);
                    check("throughput_winc", 32'(winc), 32'd1);
                end
            end
        join
        drain();

        // wfull for 5 cycles mid-stream: winc drops at once, one more word fills TWO
        fork
            stream(12, 8'h20);
            begin
                repeat (3) @(posedge wclk);
                #1;
                wfull = 1'b1;
                @(negedge wclk);
                check("full_winc_same_cycle", 32'(winc), 32'd0);
                check("full_head_held", 32'(wdata), 32'h22);
                @(negedge wclk);
                check("full_two_ready_low", 32'(s_ready), 32'd0);
                repeat (4) @(posedge wclk);
                #1;
                check("full_still_not_ready", 32'(s_ready), 32'd0);
                wfull = 1'b0;
            end
        join
        drain();

        // Level and almost-full, including pointer wrap
        wptr     = gray(6'd20);
        wq2_rptr = gray(6'd0);
        check("level_latency", 32'(wlevel), 32'd0);
        level_case("lvl20", 6'd20, 6'd0, 6'd20, 1'b0);
        level_case("lvl20_wrap", 6'd8, 6'd52, 6'd20, 1'b0);
        level_case("lvl27", 6'd27, 6'd0, 6'd27, 1'b0);
        level_case("lvl28", 6'd28, 6'd0, 6'd28, 1'b1);
        level_case("lvl32_wrap", 6'd2, 6'd34, 6'd32, 1'b1);
        level_case("lvl30", 6'd30, 6'd0, 6'd30, 1'b1);

        // Reset with the buffer in TWO
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        @(posedge wclk);
        #1;
        s_data = 8'h66;
        @(posedge wclk);
        #1;
        check("two_before_reset_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        wrst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        s_valid = 1'b0;
        wfull   = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge wclk);
            check("after_reset_no_winc", 32'(winc), 32'd0);
        end

`ifdef FIFO_WR_STREAM_STATS_EN
        @(posedge wclk);
        #1;
        fork
            stream(10, 8'h40);
            begin
                repeat (3) @(posedge wclk);
                #1;
                wfull = 1'b1;
                repeat (4) @(posedge wclk);
                #1;
                wfull = 1'b0;
            end
        join
        drain();
        check("stats_wr_count", wr_count, 32'd10);
        check("stats_stall_count", stall_count, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
